instr_decode_stage: RTL and testbench

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

---
 rtl/instr_decode_stage.sv | 208 ++++++++++++++++++++
 tb/tb_instr_decode_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// RV32I decode stage (OP, OP-IMM, EBREAK) with a 2-entry output/skid buffer and RUN/DRAIN/HALT control.
// Optional macro DECODE_ILLEGAL_TRAP_EN: unsupported words trap like EBREAK and set the sticky illegal flag.

package instr_decode_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic alu_use_imm;
    logic is_ebreak;
  } instr_flags_t;
endpackage

// state | meaning
// RUN   | accepting and decoding words
// DRAIN | terminating word accepted, emptying the buffer, no further accepts
// HALT  | terminating word delivered, idle until reset
module instr_decode_stage
  import instr_decode_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [31:0]  in_word,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output alu_op_e      out_op,
  output logic [4:0]   out_dst,
  output logic [4:0]   out_src1,
  output logic [4:0]   out_src2,
  output logic [31:0]  out_imm,
  output instr_flags_t out_flags,
  output logic         halted,
  output logic         illegal
);

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;

  // term marks an entry whose delivery moves DRAIN to HALT
  typedef struct packed {
    alu_op_e      op;
    logic [4:0]   dst;
    logic [4:0]   src1;
    logic [4:0]   src2;
    logic [31:0]  imm;
    instr_flags_t flags;
    logic         term;
  } entry_t;

  function automatic entry_t decode(input logic [31:0] w, output logic bad);
    entry_t e;
    logic   ok;
    e   = '0;
    ok  = 1'b1;
    bad = 1'b0;
    case (w[6:0])
      7'b0110011: begin
        e.dst  = w[11:7];
        e.src1 = w[19:15];
        e.src2 = w[24:20];
        case ({w[31:25], w[14:12]})
          {7'h00, 3'd0}: e.op = ALU_ADD;
          {7'h20, 3'd0}: e.op = ALU_SUB;
          {7'h00, 3'd1}: e.op = ALU_SLL;
          {7'h00, 3'd2}: e.op = ALU_SLT;
          {7'h00, 3'd3}: e.op = ALU_SLTU;
          {7'h00, 3'd4}: e.op = ALU_XOR;
          {7'h00, 3'd5}: e.op = ALU_SRL;
          {7'h20, 3'd5}: e.op = ALU_SRA;
          {7'h00, 3'd6}: e.op = ALU_OR;
          {7'h00, 3'd7}: e.op = ALU_AND;
          default:       ok   = 1'b0;
        endcase
      end
      7'b0010011: begin
        e.dst               = w[11:7];
        e.src1              = w[19:15];
        e.flags.alu_use_imm = 1'b1;
        e.imm               = {{20{w[31]}}, w[31:20]};
        case (w[14:12])
          3'd0: e.op = ALU_ADD;
          3'd2: e.op = ALU_SLT;
          3'd3: e.op = ALU_SLTU;
          3'd4: e.op = ALU_XOR;
          3'd6: e.op = ALU_OR;
          3'd7: e.op = ALU_AND;
          3'd1: begin
            e.op  = ALU_SLL;
            e.imm = {27'd0, w[24:20]};
            ok    = (w[31:25] == 7'h00);
          end
          default: begin
            e.op  = (w[30]) ? ALU_SRA : ALU_SRL;
            e.imm = {27'd0, w[24:20]};
            ok    = (w[31:25] == 7'h00) || (w[31:25] == 7'h20);
          end
        endcase
      end
      default: begin
        if (w == EBREAK_WORD) begin
          e.flags.is_ebreak = 1'b1;
          e.term            = 1'b1;
        end else begin
          ok = 1'b0;
        end
      end
    endcase
    if (!ok) begin
      e = '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      e.term = 1'b1;
      bad    = 1'b1;
`else
      e.flags.alu_use_imm = 1'b1;
`endif
    end
    return e;
  endfunction

  state_e state_q, state_d;
  entry_t out_q, out_d, skid_q, skid_d, dec;
  logic   out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic   in_ready_q, in_ready_d, illegal_q, illegal_d;
  logic   dec_bad, acc, pop;

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    illegal_d  = illegal_q;
    dec        = decode(in_word, dec_bad);
    acc        = in_valid && in_ready_q;
    pop        = out_vld_q && out_ready;

    // skid is only filled when the output register is held; in_ready is low while it is full
    if (!out_vld_q || pop) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (acc) begin
        out_d     = dec;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (acc) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end

    case (state_q)
      RUN:     if (acc && dec.term) state_d = DRAIN;
      DRAIN:   if (pop && out_q.term) state_d = HALT;
      default: state_d = HALT;
    endcase

    if (acc && dec_bad) illegal_d = 1'b1;
    in_ready_d = !skid_vld_d && (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
      illegal_q  <= illegal_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_vld_q;
  assign out_op    = out_q.op;
  assign out_dst   = out_q.dst;
  assign out_src1  = out_q.src1;
  assign out_src2  = out_q.src2;
  assign out_imm   = out_q.imm;
  assign out_flags = out_q.flags;
  assign halted    = (state_q == HALT);
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: queue-based reference model checked every cycle, directed and random stimulus.
module tb_instr_decode_stage;
  import instr_decode_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [31:0]  in_word = 32'd0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  alu_op_e      out_op;
  logic [4:0]   out_dst, out_src1, out_src2;
  logic [31:0]  out_imm;
  instr_flags_t out_flags;
  logic         halted, illegal;

  int total = 0;
  int bad = 0;

  instr_decode_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_dst(out_dst),
    .out_src1(out_src1), .out_src2(out_src2), .out_imm(out_imm), .out_flags(out_flags),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    alu_op_e     op;
    logic [4:0]  dst, src1, src2;
    logic [31:0] imm;
    bit          use_imm, ebreak, term, bad;
  } mexp_t;

  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'd0: return ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // reference decode from the instruction-set rules
  function automatic mexp_t mdl(input logic [31:0] w);
    mexp_t r;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = w[6:0]; f7 = w[31:25]; f3 = w[14:12];
    r.op = ALU_ADD; r.dst = 0; r.src1 = 0; r.src2 = 0; r.imm = 0;
    r.use_imm = 0; r.ebreak = 0; r.term = 0; r.bad = 0;
    if (w == 32'h0010_0073) begin
      r.ebreak = 1; r.term = 1;
    end else if (opc == 7'h33 && (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)))) begin
      r.op = (f7 == 0) ? base_op(f3) : ((f3 == 0) ? ALU_SUB : ALU_SRA);
      r.dst = w[11:7]; r.src1 = w[19:15]; r.src2 = w[24:20];
    end else if (opc == 7'h13 && (f3 != 1 || f7 == 0) && (f3 != 5 || f7 == 0 || f7 == 7'h20)) begin
      r.op = (f3 == 5 && f7 == 7'h20) ? ALU_SRA : base_op(f3);
      r.dst = w[11:7]; r.src1 = w[19:15]; r.use_imm = 1;
      if (f3 == 1 || f3 == 5) r.imm = 32'(w[24:20]);
      else r.imm = 32'($signed(w[31:20]));
    end else begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      r.term = 1; r.bad = 1;
`else
      r.use_imm = 1;
`endif
    end
    return r;
  endfunction

  mexp_t q[$];
  bit exp_in_ready = 1, stopping = 0, exp_halted = 0, exp_illegal = 0;
  bit just_reset = 0, checking = 0, last_acc = 0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      exp_in_ready = 1; stopping = 0; exp_halted = 0; exp_illegal = 0;
      just_reset = 1; checking = 1; last_acc = 0;
    end else if (checking) begin
      bit acc, pop;
      mexp_t f;
      just_reset = 0;
      pop = (q.size() > 0) && out_ready;
      acc = in_valid && exp_in_ready;
      if (pop) begin
        f = q.pop_front();
        if (f.term) exp_halted = 1;
      end
      if (acc) begin
        f = mdl(in_word);
        q.push_back(f);
        if (f.term) stopping = 1;
        if (f.bad) exp_illegal = 1;
      end
      last_acc = acc;
      exp_in_ready = (q.size() < 2) && !stopping && !exp_halted;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("in_ready", 32'(in_ready), 32'(exp_in_ready));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("halted", 32'(halted), 32'(exp_halted));
      chk("illegal", 32'(illegal), 32'(exp_illegal));
      if (q.size() > 0) begin
        chk("op", 32'(out_op), 32'(q[0].op));
        chk("dst", 32'(out_dst), 32'(q[0].dst));
        chk("src1", 32'(out_src1), 32'(q[0].src1));
        chk("src2", 32'(out_src2), 32'(q[0].src2));
        chk("imm", out_imm, q[0].imm);
        chk("use_imm", 32'(out_flags.alu_use_imm), 32'(q[0].use_imm));
        chk("is_ebreak", 32'(out_flags.is_ebreak), 32'(q[0].ebreak));
      end else if (just_reset) begin
        chk("rst_op", 32'(out_op), 32'(ALU_ADD));
        chk("rst_data", {out_dst, out_src1, out_src2, 15'd0, out_flags}, 32'd0);
        chk("rst_imm", out_imm, 32'd0);
      end
    end
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1; in_valid = 0; out_ready = 0;
    repeat (n) @(negedge clk);
    reset = 0;
  endtask

  task automatic send(input logic [31:0] w);
    @(negedge clk);
    in_valid = 1; in_word = w;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (last_acc) begin
        in_valid = 0;
        return;
      end
    end
    total++; bad++;
    $display("FAIL send_timeout word=%h not accepted, required acceptance", w);
    in_valid = 0;
  endtask

  function automatic logic [31:0] rand_word(input bit allow_wild);
    int k;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] w;
    k = $urandom_range(0, 9);
    f3 = 3'($urandom_range(0, 7));
    w = $urandom;
    if (k >= 8 && allow_wild) begin
      if (w == 32'h0010_0073) w = 32'hFFFF_FFFF;
      return w;
    end
    if (k < 4) begin
      f7 = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      return {f7, w[24:15], f3, w[11:7], 7'h33};
    end
    if (f3 == 1) f7 = 7'h00;
    else if (f3 == 5) f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    else f7 = w[31:25];
    return {f7, w[24:15], f3, w[11:7], 7'h13};
  endfunction

  initial begin
    mexp_t m;
    // hand-computed pins for the reference decode
    m = mdl(32'h00A0_0093);
    chk("pin_addi_imm", m.imm, 32'd10);
    chk("pin_addi_dst", 32'(m.dst), 32'd1);
    m = mdl(32'hFFF0_0193);
    chk("pin_neg_imm", m.imm, 32'hFFFF_FFFF);
    m = mdl(32'h41F1_D213);
    chk("pin_srai_op", 32'(m.op), 32'(ALU_SRA));
    chk("pin_srai_imm", m.imm, 32'd31);
    m = mdl(32'h4012_02B3);
    chk("pin_sub", {28'(m.op), 4'(m.src2)}, {28'(ALU_SUB), 4'd1});

    do_reset(2);
    out_ready = 1;
    send(32'h00A0_0093);
    send(32'h0280_8093);
    send(32'h0010_8133);
    send(32'hFFF0_0193);
    send(32'h41F1_D213);
    repeat (3) @(negedge clk);

    // stall with input pressure: exactly two words buffered
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_word = rand_word(0);
      @(negedge clk);
    end
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_depth", 32'(q.size()), 32'd2);
    in_valid = 0; out_ready = 1;
    repeat (4) @(negedge clk);

    for (int c = 0; c < 3000; c++) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      in_word = rand_word(0);
`else
      in_word = rand_word(1);
`endif
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end

    // reset with both entries full
    in_valid = 1; out_ready = 0; in_word = 32'h0010_8133;
    repeat (3) @(negedge clk);
    reset = 1; in_valid = 0;
    @(negedge clk);
    reset = 0;
    chk("rst_full_in_ready", 32'(in_ready), 32'd1);
    chk("rst_full_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);

`ifndef DECODE_ILLEGAL_TRAP_EN
    out_ready = 1;
    send(32'hFFFF_FFFF);
    send(32'h00A0_0093);
    repeat (3) @(negedge clk);
    chk("nop_illegal", 32'(illegal), 32'd0);
`endif

    do_reset(1);
    out_ready = 1;
    send(32'h4012_02B3);
    send(32'h0010_0073);
    in_valid = 1; in_word = 32'h0010_8133;
    repeat (8) @(negedge clk);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_out_valid", 32'(out_valid), 32'd0);
    in_valid = 0;

`ifdef DECODE_ILLEGAL_TRAP_EN
    do_reset(1);
    out_ready = 1;
    send(32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    chk("trap_illegal", 32'(illegal), 32'd1);
    chk("trap_halted", 32'(halted), 32'd1);
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
